// File: rtl/pinaipple_chip_emulator_pkg.sv
// Shared types and geometry for the PinAIpple chip emulator.
// Latency: n/a (types only). Backpressure: n/a.
package pinaipple_chip_pkg;

    localparam int NArray     = 2;
    localparam int NRow       = 5;
    localparam int NCol       = 3;
    localparam int ProgCycles = 4;

    localparam int NumArr  = 1 << NArray;
    localparam int NumRows = 1 << NRow;
    localparam int NumCols = 1 << NCol;
    localparam int RowBits = NumArr * NumCols;

    typedef enum logic [1:0] {
        INSTR_INFER    = 2'b00,
        INSTR_READ_REG = 2'b01,
        INSTR_READ_MEM = 2'b10,
        INSTR_PROG     = 2'b11
    } instr_e;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        PROG,
        HOLD
    } emu_state_e;

    // Position of cell (array, col) inside one physical 32-bit row word.
    function automatic logic [NArray+NCol-1:0] bit_idx(input logic [NArray-1:0] arr,
                                                       input logic [NCol-1:0]   col);
        return {arr, col};
    endfunction

endpackage

// File: rtl/pinaipple_chip_emulator_if.sv
// Chip pin bundle between the system-side driver (master) and the emulator (slave).
// Latency: n/a (wires only). Backpressure: none, pins are free-running.
interface pinaipple_chip_emulator_if;
    import pinaipple_chip_pkg::*;

    logic                    CBL;
    logic                    CBLEN;
    logic                    CSL;
    logic                    CWL;
    logic [1:0]              instructions;
    logic [NArray+NCol-1:0]  addr_col;
    logic [NRow-1:0]         addr_row;
    logic                    bit_out [NumArr];
    logic                    busy_o;

    modport master (
        output CBL, CBLEN, CSL, CWL, instructions, addr_col, addr_row,
        input  bit_out, busy_o
    );

    modport slave (
        input  CBL, CBLEN, CSL, CWL, instructions, addr_col, addr_row,
        output bit_out, busy_o
    );

endinterface

// File: rtl/pinaipple_chip_emulator_chip_cell_array.sv
// 32 x 32-bit cell store: all four arrays side by side in one row word.
// Latency: async row read, write lands on the clock edge. Backpressure: none.
module chip_cell_array
    import pinaipple_chip_pkg::*;
(
    input  logic               clk_i,
    input  logic [NRow-1:0]    rd_row_i,
    output logic [RowBits-1:0] rd_data_o,
    input  logic               wr_en_i,
    input  logic [NRow-1:0]    wr_row_i,
    input  logic [RowBits-1:0] wr_mask_i,
    input  logic [RowBits-1:0] wr_data_i
);

    logic [RowBits-1:0] mem_q [NumRows];

    assign rd_data_o = mem_q[rd_row_i];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            for (int b = 0; b < RowBits; b++) begin
                if (wr_mask_i[b]) begin
                    mem_q[wr_row_i][b] <= wr_data_i[b];
                end
            end
        end
    end

endmodule

// File: rtl/pinaipple_chip_emulator.sv
// Chip-side responder: clear sweep, pulse-qualified programming, CSL-edge inference capture.
// Latency: bit_out registered, 1 cycle after the sampling edge. Backpressure: none; busy_o is debug only.
module pinaipple_chip_emulator
    import pinaipple_chip_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    pinaipple_chip_emulator_if.slave  pin
);

    emu_state_e             state_q, state_d;
    logic [NRow-1:0]        cnt_q, cnt_d;
    logic [NRow-1:0]        lat_row_q, lat_row_d;
    logic [NArray+NCol-1:0] lat_col_q, lat_col_d;
    logic                   lat_cbl_q, lat_cbl_d;
    logic                   csl_q, csl_d;
    logic                   busy_q, busy_d;
    logic [NumCols-1:0]     reg_q [NumArr];
    logic [NumCols-1:0]     reg_d [NumArr];
    logic                   bit_out_q [NumArr];
    logic                   bit_out_d [NumArr];

    logic [RowBits-1:0]     row_data;
    logic                   wr_en;
    logic [NRow-1:0]        wr_row;
    logic [RowBits-1:0]     wr_mask;
    logic [RowBits-1:0]     wr_data;

    logic [NCol-1:0]        col;
    logic                   prog_req;
    logic                   prog_match;
    logic                   infer_fire;

    assign col        = pin.addr_col[NCol-1:0];
    assign prog_req   = (pin.instructions == INSTR_PROG) && pin.CBLEN && pin.CWL;
    assign prog_match = prog_req && (pin.addr_row == lat_row_q) &&
                        (pin.addr_col == lat_col_q) && (pin.CBL == lat_cbl_q);
    assign infer_fire = (pin.instructions == INSTR_INFER) && pin.CSL && !csl_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lat_row_d = lat_row_q;
        lat_col_d = lat_col_q;
        lat_cbl_d = lat_cbl_q;
        csl_d     = pin.CSL;
        reg_d     = reg_q;
        wr_en     = 1'b0;
        wr_row    = cnt_q;
        wr_mask   = '0;
        wr_data   = '0;

        unique case (state_q)
            INIT: begin
                wr_en   = 1'b1;
                wr_mask = '1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == NRow'(NumRows - 1)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (prog_req) begin
                    state_d   = PROG;
                    lat_row_d = pin.addr_row;
                    lat_col_d = pin.addr_col;
                    lat_cbl_d = pin.CBL;
                    cnt_d     = NRow'(1);
                end else if (infer_fire) begin
                    for (int k = 0; k < NumArr; k++) begin
                        reg_d[k][col] = row_data[bit_idx(NArray'(k), col)];
                    end
                end
            end
            PROG: begin
                // Any disturbance of the pulse abandons it; the commit edge is the last matching one.
                if (!prog_match) begin
                    state_d = IDLE;
                end else if (cnt_q == NRow'(ProgCycles - 1)) begin
                    wr_en   = 1'b1;
                    wr_row  = lat_row_q;
                    wr_mask = RowBits'(1) << bit_idx(lat_col_q[NCol +: NArray],
                                                     lat_col_q[NCol-1:0]);
                    wr_data = {RowBits{lat_cbl_q}};
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (!pin.CWL) begin
                    state_d = IDLE;
                end
            end
        endcase

        busy_d = (state_d != IDLE);

        for (int k = 0; k < NumArr; k++) begin
            bit_out_d[k] = 1'b0;
            if (state_q != INIT) begin
                case (pin.instructions)
                    INSTR_READ_MEM: bit_out_d[k] = row_data[bit_idx(NArray'(k), col)];
                    INSTR_READ_REG: bit_out_d[k] = reg_q[k][col];
                    default:        bit_out_d[k] = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= INIT;
            cnt_q     <= '0;
            lat_row_q <= '0;
            lat_col_q <= '0;
            lat_cbl_q <= 1'b0;
            csl_q     <= 1'b0;
            busy_q    <= 1'b1;
            for (int k = 0; k < NumArr; k++) begin
                reg_q[k]     <= '0;
                bit_out_q[k] <= 1'b0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lat_row_q <= lat_row_d;
            lat_col_q <= lat_col_d;
            lat_cbl_q <= lat_cbl_d;
            csl_q     <= csl_d;
            busy_q    <= busy_d;
            reg_q     <= reg_d;
            bit_out_q <= bit_out_d;
        end
    end

    // A reset edge must never commit a half-finished program or clear row.
    chip_cell_array u_cells (
        .clk_i     (clk_i),
        .rd_row_i  (pin.addr_row),
        .rd_data_o (row_data),
        .wr_en_i   (wr_en && !rst_i),
        .wr_row_i  (wr_row),
        .wr_mask_i (wr_mask),
        .wr_data_i (wr_data)
    );

    assign pin.bit_out = bit_out_q;
    assign pin.busy_o  = busy_q;

endmodule

// File: tb/tb_pinaipple_chip_emulator.sv
// Scoreboard bench: driver pushes model predictions per edge, monitor pops and compares.
module tb_pinaipple_chip_emulator;
    import pinaipple_chip_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    pinaipple_chip_emulator_if pin ();

    pinaipple_chip_emulator dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .pin   (pin)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0] bits;
        logic       busy;
    } exp_t;

    exp_t exp_q [$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    // Behavioural model: cell contents, inference registers and pulse bookkeeping.
    bit   m_mem [4][32][8];
    bit   m_reg [4][8];
    int   clear_left;
    int   run_len;
    bit   wait_release;
    bit   csl_prev;
    int   p_arr, p_row, p_col;
    bit   p_cbl;

    task automatic model(input bit rst, input int ins, input int arr, input int row,
                         input int col, input bit cbl, input bit cblen, input bit csl,
                         input bit cwl, output exp_t e);
        bit pulse_ok;
        bit idle;
        e.bits = 4'b0;
        if (rst) begin
            clear_left = 32; run_len = 0; wait_release = 0; csl_prev = 0;
            for (int k = 0; k < 4; k++)
                for (int c = 0; c < 8; c++) m_reg[k][c] = 0;
            e.busy = 1'b1;
            return;
        end
        if (clear_left == 0) begin
            for (int k = 0; k < 4; k++) begin
                if (ins == 2) e.bits[k] = m_mem[k][row][col];
                if (ins == 1) e.bits[k] = m_reg[k][col];
            end
        end
        idle = (clear_left == 0) && (run_len == 0) && !wait_release;
        if (idle && ins == 0 && csl && !csl_prev)
            for (int k = 0; k < 4; k++) m_reg[k][col] = m_mem[k][row][col];
        csl_prev = csl;
        pulse_ok = (ins == 3) && cblen && cwl;
        if (clear_left > 0) begin
            for (int k = 0; k < 4; k++)
                for (int c = 0; c < 8; c++) m_mem[k][32 - clear_left][c] = 0;
            clear_left--;
        end else if (wait_release) begin
            if (!cwl) wait_release = 0;
        end else if (run_len == 0) begin
            if (pulse_ok) begin
                p_arr = arr; p_row = row; p_col = col; p_cbl = cbl; run_len = 1;
            end
        end else if (pulse_ok && arr == p_arr && row == p_row && col == p_col && cbl == p_cbl) begin
            run_len++;
            if (run_len == ProgCycles) begin
                m_mem[p_arr][p_row][p_col] = p_cbl;
                run_len = 0;
                wait_release = 1;
            end
        end else begin
            run_len = 0;
        end
        e.busy = (clear_left > 0) || (run_len > 0) || wait_release;
    endtask

    task automatic step(input bit rst, input int ins, input int arr, input int row,
                        input int col, input bit cbl, input bit cblen, input bit csl,
                        input bit cwl);
        exp_t e;
        @(negedge clk_i);
        rst_i            = rst;
        pin.instructions = 2'(ins);
        pin.addr_col     = 5'(arr * 8 + col);
        pin.addr_row     = 5'(row);
        pin.CBL          = cbl;
        pin.CBLEN        = cblen;
        pin.CSL          = csl;
        pin.CWL          = cwl;
        model(rst, ins, arr, row, col, cbl, cblen, csl, cwl, e);
        exp_q.push_back(e);
    endtask

    task automatic pulse(input int arr, input int row, input int col, input bit cbl,
                         input int len, input int glitch_at);
        for (int i = 0; i < len; i++)
            step(0, 3, arr, (i == glitch_at) ? (row ^ 1) : row, col, cbl, 1, 0, 1);
        step(0, 3, arr, row, col, cbl, 0, 0, 0);
    endtask

    task automatic idle_cycles(input int ins, input int arr, input int row, input int col,
                               input int n);
        for (int i = 0; i < n; i++) step(0, ins, arr, row, col, 0, 0, 0, 0);
    endtask

    // Monitor: every edge that had stimulus has exactly one queued prediction.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                logic [3:0] got;
                e = exp_q.pop_front();
                for (int k = 0; k < 4; k++) got[k] = pin.bit_out[k];
                tests_run++;
                if (got !== e.bits) begin
                    tests_failed++;
                    $display("FAIL bit_out t=%0t got %b expected %b", $time, got, e.bits);
                end
                tests_run++;
                if (pin.busy_o !== e.busy) begin
                    tests_failed++;
                    $display("FAIL busy_o t=%0t got %b expected %b", $time, pin.busy_o, e.busy);
                end
            end
        end
    end

    initial begin
        pin.instructions = 2'b10;
        pin.addr_col = '0; pin.addr_row = '0;
        pin.CBL = 0; pin.CBLEN = 0; pin.CSL = 0; pin.CWL = 0;

        // Reset, then the clear sweep observed through read_mem.
        step(1, 2, 0, 7, 5, 0, 0, 0, 0);
        idle_cycles(2, 0, 7, 5, 40);

        // Minimum-length pulse writes exactly one cell.
        pulse(2, 3, 6, 1, 4, -1);
        idle_cycles(2, 2, 3, 6, 3);

        // One cycle short: nothing written.
        pulse(1, 3, 6, 1, 3, -1);
        idle_cycles(2, 1, 3, 6, 3);

        // Row disturbed mid-pulse aborts; then a long clean pulse writes once.
        pulse(0, 3, 6, 1, 4, 2);
        idle_cycles(2, 0, 3, 6, 2);
        pulse(0, 3, 6, 1, 10, -1);
        idle_cycles(2, 0, 3, 6, 2);

        // All arrays set, CSL held high captures once, then read back registers.
        for (int k = 0; k < 4; k++) pulse(k, 3, 6, 1, 4, -1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 3, 6, 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 4, 6, 0, 0, 1, 0);
        idle_cycles(0, 0, 4, 6, 1);
        idle_cycles(1, 0, 3, 6, 3);
        idle_cycles(1, 0, 3, 5, 2);

        // Reset during a program pulse: no write, sweep restarts, registers cleared.
        step(0, 3, 3, 9, 2, 1, 1, 0, 1);
        step(0, 3, 3, 9, 2, 1, 1, 0, 1);
        step(1, 3, 3, 9, 2, 1, 1, 0, 1);
        idle_cycles(1, 0, 3, 6, 34);
        idle_cycles(2, 3, 9, 2, 2);

        // Randomised traffic on a narrow address range so cells collide often.
        for (int n = 0; n < 300; n++) begin
            int op, arr, row, col;
            bit cbl;
            op  = $urandom_range(0, 9);
            arr = $urandom_range(0, 3);
            row = $urandom_range(0, 3);
            col = $urandom_range(0, 7);
            cbl = 1'($urandom_range(0, 1));
            case (op)
                0, 1, 2: pulse(arr, row, col, cbl, $urandom_range(2, 6), $urandom_range(0, 9));
                3, 4: begin
                    for (int i = 0; i < $urandom_range(1, 3); i++)
                        step(0, 0, arr, row, col, 0, 0, 1, 0);
                    step(0, 0, arr, row, col, 0, 0, 0, 0);
                end
                5, 6: idle_cycles(2, arr, row, col, $urandom_range(1, 3));
                7, 8: idle_cycles(1, arr, row, col, $urandom_range(1, 3));
                default: begin
                    if ($urandom_range(0, 9) == 0) begin
                        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
                        idle_cycles(2, arr, row, col, 33);
                    end else begin
                        step(0, $urandom_range(0, 3), arr, row, col, cbl,
                             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                             1'($urandom_range(0, 1)));
                    end
                end
            endcase
        end

        @(posedge clk_i);
        #2;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain left %0d expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
